// File: rtl/serial_main_store_pkg.sv
// Shared types and width helpers for the bit-serial main store.
// Mode encodings match the 2-bit mode field driven by the control unit.
package serial_main_store_pkg;

   typedef enum logic [1:0] {
      MS_READ     = 2'b00,
      MS_WRITE    = 2'b01,
      MS_ZERO     = 2'b10,
      MS_EXCHANGE = 2'b11
   } ms_mode_t;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_XFER = 1'b1
   } ms_state_t;

   localparam int MS_WORD_LENGTH_DEF = 20;
   localparam int MS_DEPTH_DEF       = 32;

   // Index width for n items, never narrower than one bit.
   function automatic int ms_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_main_store_if.sv
// Bus between the serial datapath/front panel (master) and the main store (slave).
// Handshake: req is taken only on a dpg edge while idle; busy then stays high until
// the dpg edge that completes the last digit, which raises done for exactly one clk.
interface serial_main_store_if
   import serial_main_store_pkg::*;
#(
   parameter int WORD_LENGTH = MS_WORD_LENGTH_DEF,
   parameter int DEPTH       = MS_DEPTH_DEF
) ();

   localparam int ADDR_BITS = ms_width(DEPTH);
   localparam int BIT_BITS  = ms_width(WORD_LENGTH);

   logic                   dpg;
   logic                   req;
   logic [1:0]             mode;
   logic [ADDR_BITS-1:0]   addr;
   logic                   data_in;
   logic                   data_out;
   logic                   data_out_valid;
   logic [BIT_BITS-1:0]    bit_idx;
   logic                   busy;
   logic                   done;
   logic                   addr_err;
   logic [ADDR_BITS-1:0]   view_addr;
   logic [WORD_LENGTH-1:0] view_word;
   ms_state_t              state;

   modport master (
      output dpg, req, mode, addr, data_in, view_addr,
      input  data_out, data_out_valid, bit_idx, busy, done, addr_err, view_word, state
   );

   modport slave (
      input  dpg, req, mode, addr, data_in, view_addr,
      output data_out, data_out_valid, bit_idx, busy, done, addr_err, view_word, state
   );

endinterface

// File: rtl/serial_main_store_digit_counter.sv
// Digit-period counter: steps 0..WORD_LENGTH-1 on enabled clocks, wrapping after
// the last digit; clr restarts it at digit 0 when a transfer is accepted.
module ms_digit_counter
   import serial_main_store_pkg::*;
#(
   parameter int WORD_LENGTH = MS_WORD_LENGTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic                               en,
   output logic [ms_width(WORD_LENGTH)-1:0]   count,
   output logic                               last
);

   localparam int                  BIT_BITS = ms_width(WORD_LENGTH);
   localparam logic [BIT_BITS-1:0] LAST_IDX = BIT_BITS'(WORD_LENGTH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + BIT_BITS'(1);
      end
   end

   assign last = (count == LAST_IDX);

endmodule

// File: rtl/serial_main_store.sv
// Bit-serial multi-word main store: one digit per dpg period, LSB first, with
// read / write / zero / exchange transfers and a parallel monitor port.
module serial_main_store
   import serial_main_store_pkg::*;
#(
   parameter int WORD_LENGTH = MS_WORD_LENGTH_DEF,
   parameter int DEPTH       = MS_DEPTH_DEF
) (
   input logic               clk,
   input logic               rst_n,
   serial_main_store_if.slave bus
);

   localparam int                   ADDR_BITS = ms_width(DEPTH);
   localparam int                   BIT_BITS  = ms_width(WORD_LENGTH);
   localparam logic [ADDR_BITS:0]   DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);

   ms_state_t              state_q, state_d;
   ms_mode_t               mode_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [WORD_LENGTH-1:0] mem [DEPTH];
   logic [BIT_BITS-1:0]    bit_idx;
   logic                   last_digit;
   logic                   accept;
   logic                   step;
   logic                   in_range;
   logic                   rd_bit;
   logic                   wr_bit;
   logic                   wr_en;
   logic                   rd_en;
   logic                   data_out_q;
   logic                   valid_q;
   logic                   done_q;
   logic                   addr_err_q;

   // Next-state: accept only on a dpg edge while idle; leave after the last digit.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      case (state_q)
         MS_IDLE: begin
            if (bus.dpg && bus.req) begin
               accept  = 1'b1;
               state_d = MS_XFER;
            end
         end
         MS_XFER: begin
            if (bus.dpg) begin
               step = 1'b1;
               if (last_digit) begin
                  state_d = MS_IDLE;
               end
            end
         end
         default: state_d = MS_IDLE;
      endcase
   end

   ms_digit_counter #(
      .WORD_LENGTH (WORD_LENGTH)
   ) u_digit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (step),
      .count (bit_idx),
      .last  (last_digit)
   );

   assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
   assign rd_bit   = in_range ? mem[addr_q][bit_idx] : 1'b0;
   assign wr_bit   = (mode_q == MS_ZERO) ? 1'b0 : bus.data_in;
   assign wr_en    = step && in_range && (mode_q != MS_READ);
   assign rd_en    = step && ((mode_q == MS_READ) || (mode_q == MS_EXCHANGE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MS_IDLE;
         mode_q     <= MS_READ;
         addr_q     <= '0;
         data_out_q <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
         if (accept) begin
            mode_q <= ms_mode_t'(bus.mode);
            addr_q <= bus.addr;
         end
         if (rd_en) begin
            data_out_q <= rd_bit;
            valid_q    <= 1'b1;
         end
         if (step && last_digit) begin
            done_q     <= 1'b1;
            addr_err_q <= !in_range;
         end
      end
   end

   // Exchange reads the old digit here before the same edge overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[addr_q][bit_idx] <= wr_bit;
      end
   end

   always_comb begin
      bus.view_word = '0;
      if ({1'b0, bus.view_addr} < DEPTH_LIM) begin
         bus.view_word = mem[bus.view_addr];
      end
   end

   assign bus.data_out       = data_out_q;
   assign bus.data_out_valid = valid_q;
   assign bus.bit_idx        = bit_idx;
   assign bus.busy           = (state_q == MS_XFER);
   assign bus.done           = done_q;
   assign bus.addr_err       = addr_err_q;
   assign bus.state          = state_q;

endmodule

// File: doc/serial_main_store.md
# serial_main_store

Parametrised bit-serial main store for the reduced machine: DEPTH words of WORD_LENGTH bits, transferred one digit per digit-pulse (DPG) period, least significant digit first. It replaces the fixed two-word store with a general multi-word store supporting read, write, zero and exchange (read-old/write-new) transfers, framed by a req/busy/done handshake. It sits between the control/accumulator serial datapath and the front-panel display, which reads any word in parallel through a monitor port.

## Interface
- WORD_LENGTH, 20, digits per word (>= 2)
- DEPTH, 32, number of words (>= 2, need not be a power of two)
- ADDR_BITS, $clog2(DEPTH), derived; address width
- BIT_BITS, $clog2(WORD_LENGTH), derived; digit index width

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dpg  in  1  digit pulse; state advances only on clk edges with dpg=1
- req  in  1  transfer request, sampled on dpg edges in IDLE
- mode  in  2  00 READ, 01 WRITE, 10 ZERO, 11 EXCHANGE
- addr  in  ADDR_BITS  word address, latched on accept
- data_in  in  1  serial write digit, sampled on dpg edges in XFER
- data_out  out  1  serial read digit (registered)
- data_out_valid  out  1  one-clk pulse qualifying data_out
- bit_idx  out  BIT_BITS  current digit index
- busy  out  1  high while in XFER
- done  out  1  one-clk pulse, transfer complete
- addr_err  out  1  one-clk pulse with done when latched addr >= DEPTH
- view_addr  in  ADDR_BITS  monitor address
- view_word  out  WORD_LENGTH  combinational mem[view_addr]; 0 if out of range

## Operation
- States: IDLE, XFER.
- IDLE: on dpg=1 and req=1 latch addr and mode, bit_idx<=0, go XFER. req with dpg=0 is not accepted.
- XFER, each dpg=1 edge, digit k=bit_idx of latched word:
  - READ: data_out<=mem[k], data_out_valid<=1.
  - WRITE: mem[k]<=data_in.
  - ZERO: mem[k]<=0.
  - EXCHANGE: data_out<=old mem[k], mem[k]<=data_in on the same edge (old value read).
  - k=WORD_LENGTH-1: go IDLE, done<=1, bit_idx<=0; else bit_idx<=k+1.
- dpg=0 in XFER: hold state, memory, bit_idx; valid and done are low (pulses never stretch).
- req, mode, addr ignored while busy.
- Out-of-range addr: transfer runs full length, no memory write, data_out=0 with valid still pulsed, addr_err pulses with done.
- Reset (any time, including mid-transfer): IDLE, whole store cleared to 0, all outputs 0, bit_idx=0. Partial write digits are discarded by the clear.

## Timing
- dpg tied high, req accepted at edge 0: busy high cycles 1..WORD_LENGTH; digit k sampled/written at edge k+1; data_out digit k valid in cycle k+2; done, addr_err and last valid in cycle WORD_LENGTH+1, busy low the same cycle.
- Back-to-back: new req accepted on the edge ending cycle WORD_LENGTH+1; no dead digit period beyond accept.
- Accept occupies one dpg period; a transfer costs WORD_LENGTH+1 dpg periods.
- view_word is combinational; reflects a write from the edge after it.

## Structure
- Shared package: mode encodings (MS_READ, MS_WRITE, MS_ZERO, MS_EXCHANGE), state enum, width helpers.
- One sub-module: ms_digit_counter — dpg-enabled 0..WORD_LENGTH-1 counter with clear and last flag; drives bit_idx.
- Storage: flop array, async-cleared.

## Test plan
- Reset: release rst_n -> view_word=0 for all 32 addresses; busy, done, data_out_valid, data_out, addr_err = 0.
- WRITE addr 3, serial 0xA5A5A LSB first, dpg high -> done in cycle 21, view_addr=3 gives 0xA5A5A, other words 0.
- READ addr 3 -> valid cycles 2..21, data_out 0,1,0,1,1,0,1,0,... reassembles 0xA5A5A; memory unchanged.
- EXCHANGE addr 3 with 0x12345 -> output stream 0xA5A5A, then view_word 0x12345; ZERO addr 3 -> view_word 0.
- dpg high every third cycle, req re-pulsed while busy -> transfer length 63 clks, one done, extra req ignored, valid pulses exactly 1 clk each.
- DEPTH=24 instance, WRITE addr 30 -> addr_err with done, no change; rst_n low at bit 7 of a write -> IDLE, busy 0, store all 0.
